// File: rtl/sbox_cf_compress.sv
// Masked S-box share compression: registers 27 expanded shares per coordinate, then folds them into 3 output shares.
// Latency: 2 cycles from input handshake to out_valid; one column per cycle when out_ready is high.
// Backpressure: out_ready low holds stage 2; stage 1 fills once, then in_ready drops until the stall clears.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous clear of both pipeline stages, column counter and layer_done
//   in_valid/in_ready   - input handshake for in_q0..in_q3 (27 expanded shares of coordinate functions 0..3)
//   out_y1..out_y3      - compressed output shares; bit f belongs to coordinate function f
//   out_valid/out_ready - output handshake
//   col_idx             - column index of the result on out_y*, wraps at NCOL
//   layer_done          - one-cycle pulse after the handshake of column NCOL-1
module sbox_cf_compress #(
    parameter int NCOL = 16,
    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [26:0]   in_q0,
    input  logic [26:0]   in_q1,
    input  logic [26:0]   in_q2,
    input  logic [26:0]   in_q3,
    output logic [3:0]    out_y1,
    output logic [3:0]    out_y2,
    output logic [3:0]    out_y3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] col_idx,
    output logic          layer_done
);

    // Expanded share n belongs to output share (n mod 3) + 1; each octal digit covers one group of 3 shares.
    localparam logic [26:0] MASK_S1 = 27'o111111111;
    localparam logic [26:0] MASK_S2 = 27'o222222222;
    localparam logic [26:0] MASK_S3 = 27'o444444444;
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

    logic        s1_valid;
    logic        s2_valid;
    logic [26:0] s1_q0, s1_q1, s1_q2, s1_q3;
    logic        s1_move;
    logic        s2_load;
    logic        in_hs;
    logic        out_hs;
    logic [3:0]  y1_nxt, y2_nxt, y3_nxt;

    assign s1_move   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~flush & (~s1_valid | s1_move);
    assign in_hs     = in_valid & in_ready;
    // Flush wins over any transfer in the same cycle.
    assign s2_load   = s1_move & ~flush;
    assign out_hs    = s2_valid & out_ready & ~flush;
    assign out_valid = s2_valid;

    // Compression reads only the stage-1 registers, so no share mixing happens on raw inputs.
    always_comb begin
        y1_nxt = {^(s1_q3 & MASK_S1), ^(s1_q2 & MASK_S1), ^(s1_q1 & MASK_S1), ^(s1_q0 & MASK_S1)};
        y2_nxt = {^(s1_q3 & MASK_S2), ^(s1_q2 & MASK_S2), ^(s1_q1 & MASK_S2), ^(s1_q0 & MASK_S2)};
        y3_nxt = {^(s1_q3 & MASK_S3), ^(s1_q2 & MASK_S3), ^(s1_q1 & MASK_S3), ^(s1_q0 & MASK_S3)};
    end

    // Stage 1: raw share capture (glitch barrier).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q0    <= '0;
            s1_q1    <= '0;
            s1_q2    <= '0;
            s1_q3    <= '0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (in_hs)   s1_valid <= 1'b1;
            else if (s1_move) s1_valid <= 1'b0;
            // Data registers load only on an accepted column to keep share registers quiet otherwise.
            if (in_hs) begin
                s1_q0 <= in_q0;
                s1_q1 <= in_q1;
                s1_q2 <= in_q2;
                s1_q3 <= in_q3;
            end
        end
    end

    // Stage 2: compressed shares, column counter and layer pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_y1     <= '0;
            out_y2     <= '0;
            out_y3     <= '0;
            col_idx    <= '0;
            layer_done <= 1'b0;
        end else begin
            if (flush)          s2_valid <= 1'b0;
            else if (s1_move)   s2_valid <= 1'b1;
            else if (out_ready) s2_valid <= 1'b0;
            if (s2_load) begin
                out_y1 <= y1_nxt;
                out_y2 <= y2_nxt;
                out_y3 <= y3_nxt;
            end
            if (flush) begin
                col_idx    <= '0;
                layer_done <= 1'b0;
            end else begin
                layer_done <= out_hs & (col_idx == LAST_COL);
                if (out_hs) col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sbox_cf_compress.sv
// Self-checking bench for sbox_cf_compress: directed share-mapping, stall, flush and reset cases plus random traffic.
// Reference: a queue of accepted columns with accept timestamps; each column is due at the output 2 cycles after accept.
// Inputs are driven 1 time unit after the rising edge, outputs are checked on the falling edge.
module tb_sbox_cf_compress;

    localparam int NCOL = 16;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [26:0]   in_q0, in_q1, in_q2, in_q3;
    logic [3:0]    out_y1, out_y2, out_y3;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] col_idx;
    logic          layer_done;

    sbox_cf_compress #(.NCOL(NCOL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_q0(in_q0), .in_q1(in_q1), .in_q2(in_q2), .in_q3(in_q3),
        .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .col_idx(col_idx), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [107:0] dq[$];
    int           aq[$];
    int           cyc     = 0;
    int           exp_col = 0;
    logic         ld_exp  = 1'b0;

    // Observation counters for directed scenarios
    int dut_acc = 0;
    int ld_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output share s collects every third expanded share starting at index s-1.
    function automatic logic [11:0] ref_comp(input logic [107:0] d);
        logic [11:0] y;
        y = '0;
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < 27; n++)
                y[(n % 3) * 4 + f] = y[(n % 3) * 4 + f] ^ d[f * 27 + n];
        return y;
    endfunction

    function automatic logic [3:0] ref_parity(input logic [107:0] d);
        logic [3:0] p;
        for (int f = 0; f < 4; f++) begin
            p[f] = 1'b0;
            for (int n = 0; n < 27; n++) p[f] = p[f] ^ d[f * 27 + n];
        end
        return p;
    endfunction

    task automatic model_clear();
        dq.delete();
        aq.delete();
        exp_col = 0;
        ld_exp  = 1'b0;
    endtask

    task automatic set_q(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c, input logic [26:0] d);
        in_q0 = a; in_q1 = b; in_q2 = c; in_q3 = d;
    endtask

    task automatic set_rand_q();
        set_q(27'($urandom()), 27'($urandom()), 27'($urandom()), 27'($urandom()));
    endtask

    // One clock cycle: check at the falling edge, advance the reference at the rising edge.
    task automatic tick();
        logic         exp_ov, exp_rdy, in_hs, out_hs;
        logic [11:0]  y;
        logic [107:0] cur;
        @(negedge clk);
        exp_ov  = (dq.size() > 0) && (cyc - aq[0] >= 2);
        exp_rdy = !flush && (dq.size() < 2 || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("col_idx", 32'(col_idx), 32'(exp_col));
        chk("layer_done", 32'(layer_done), 32'(ld_exp));
        if (exp_ov) begin
            y = ref_comp(dq[0]);
            chk("out_y1", 32'(out_y1), 32'(y[3:0]));
            chk("out_y2", 32'(out_y2), 32'(y[7:4]));
            chk("out_y3", 32'(out_y3), 32'(y[11:8]));
        end
        in_hs  = in_valid && exp_rdy;
        out_hs = exp_ov && out_ready && !flush;
        if (out_hs) chk("unmask", 32'(out_y1 ^ out_y2 ^ out_y3), 32'(ref_parity(dq[0])));
        if (in_valid && in_ready) dut_acc++;
        if (layer_done) ld_cnt++;
        cur = {in_q3, in_q2, in_q1, in_q0};
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            ld_exp = 1'b0;
            if (out_hs) begin
                ld_exp  = (exp_col == NCOL - 1);
                exp_col = (exp_col + 1) % NCOL;
                void'(dq.pop_front());
                void'(aq.pop_front());
            end
            if (in_hs) begin
                dq.push_back(cur);
                aq.push_back(cyc);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (n) tick();
    endtask

    // Send one directed column into an empty pipe and return with its result on the outputs.
    task automatic directed(input string tag, input logic [26:0] a, input logic [26:0] b,
                            input logic [26:0] c, input logic [26:0] d, input logic [11:0] exp_y);
        set_q(a, b, c, d);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_y1"}, 32'(out_y1), 32'(exp_y[3:0]));
        chk({tag, "_y2"}, 32'(out_y2), 32'(exp_y[7:4]));
        chk({tag, "_y3"}, 32'(out_y3), 32'(exp_y[11:8]));
        tick();
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_col_idx", 32'(col_idx), 32'd0);
        chk("rst_layer_done", 32'(layer_done), 32'd0);
        chk("rst_out_y", 32'({out_y1, out_y2, out_y3}), 32'd0);
        model_clear();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    int first_ov;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_q('0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("por_out_valid", 32'(out_valid), 32'd0);
        chk("por_col_idx", 32'(col_idx), 32'd0);
        chk("por_out_y", 32'({out_y1, out_y2, out_y3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 16 random columns back-to-back
        ld_cnt = 0; first_ov = -1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) in_valid = 1'b0;
            set_rand_q();
            if (out_valid && first_ov < 0) first_ov = i;
            tick();
        end
        chk("stream_latency", 32'(first_ov), 32'd2);
        chk("stream_layer_done_cnt", 32'(ld_cnt), 32'd1);
        chk("stream_col_wrap", 32'(col_idx), 32'd0);

        // Share mapping
        directed("map_q0b0", 27'h0000001, '0, '0, '0, 12'h001);
        directed("map_q0b1", 27'h0000002, '0, '0, '0, 12'h010);
        directed("map_q3b26", '0, '0, '0, 27'h4000000, 12'h800);

        // Stall: out_ready low for 4 cycles with in_valid high
        idle(3);
        dut_acc = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (4) begin set_rand_q(); tick(); end
        chk("stall_accepted", 32'(dut_acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        idle(5);

        // Flush with two columns in flight and a simultaneous input
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (2) begin set_rand_q(); tick(); end
        dut_acc = 0;
        flush = 1'b1; out_ready = 1'b1; set_rand_q();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_acc", 32'(dut_acc), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_col_idx", 32'(col_idx), 32'd0);
        chk("flush_layer_done", 32'(layer_done), 32'd0);
        idle(4);

        // Asynchronous reset in the middle of a layer at column 7
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_col != 7; i++) begin set_rand_q(); tick(); end
        chk("pre_rst_col", 32'(col_idx), 32'd7);
        async_reset();
        set_rand_q(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_first_vld", 32'(out_valid), 32'd1);
        chk("rst_first_col", 32'(col_idx), 32'd0);
        idle(3);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(63) == 0);
            set_rand_q();
            tick();
        end
        idle(6);
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_cf_compress.md
SBOX_CF_COMPRESS -- requirements
Module: sbox_cf_compress

Interface
REQ-001 SHALL have parameter NCOL, default 16, meaning the number of S-box columns per substitution layer.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, synchronous clear of pipeline and column counter.
REQ-005 SHALL have port in_valid, input, 1, meaning the expanded share vectors are valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts input this cycle.
REQ-007 SHALL have ports in_q0, in_q1, in_q2, in_q3, input, 27 each, meaning the 27 expanded shares of coordinate functions 0..3.
REQ-008 SHALL have ports out_y1, out_y2, out_y3, output, 4 each, meaning output share s with bit f for coordinate f.
REQ-009 SHALL have port out_valid, output, 1, meaning out_y1..3 hold a compressed result.
REQ-010 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.
REQ-011 SHALL have port col_idx, output, log2(NCOL), meaning the column index of the result currently on out_y*.
REQ-012 SHALL have port layer_done, output, 1, a one-cycle pulse marking a completed layer.

Function
REQ-013 SHALL be a two-stage pipeline: stage 1 registers in_q0..3 unmodified (glitch barrier); stage 2 registers compressed shares.
REQ-014 SHALL accept input only on in_valid & in_ready; SHALL compute in_ready = !flush & (!s1_valid | s1_move), with s1_move = s1_valid & (!s2_valid | out_ready).
REQ-015 SHALL compress in stage 2 as out_ys[f] = XOR of in_qf[n] over all n in 0..26 with n mod 3 = s-1 (9 terms per share bit).
REQ-016 SHALL perform no XOR or other logic on shares before the stage-1 register.
REQ-017 SHALL drive out_valid = s2_valid; on out_valid & !out_ready, out_y*, col_idx and out_valid SHALL hold.
REQ-018 SHALL have latency 2 cycles from input handshake to out_valid with no stall; throughput one column per cycle.
REQ-019 SHALL never drop or duplicate a column under any in_valid/out_ready pattern.
REQ-020 SHALL increment col_idx on every output handshake (out_valid & out_ready), wrapping NCOL-1 -> 0.
REQ-021 SHALL assert layer_done for exactly one cycle, in the cycle after the handshake of column NCOL-1.
REQ-022 SHALL, on flush, clear s1_valid, s2_valid, col_idx, layer_done at the next edge; flush SHALL take precedence over a simultaneous input or output handshake, neither of which counts.
REQ-023 SHALL keep out_y* data registers unchanged when their stage does not load (no toggling of share registers on idle cycles).
REQ-024 SHALL preserve the unmasked value: out_y1 ^ out_y2 ^ out_y3 equals, per bit f, the XOR of all 27 bits of in_qf.

Reset
REQ-025 SHALL, while rst_n = 0, force s1_valid = 0, out_valid = 0, col_idx = 0, layer_done = 0, out_y1 = out_y2 = out_y3 = 4'h0, and all stage-1 share registers to 0, independent of clk.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts (flush low).
REQ-027 SHALL discard any column in flight when reset asserts mid-operation; no partial result SHALL appear after release.

Verification
REQ-028 SHALL check share mapping: in_q0 = 27'h0000001 -> out_y1 = 4'h1, out_y2 = out_y3 = 4'h0; in_q0 = 27'h0000002 -> out_y2 = 4'h1; in_q3 = 27'h4000000 (bit 26) -> out_y3 = 4'h8.
REQ-029 SHALL stream 16 random columns back-to-back with out_ready = 1 -> out_valid first high 2 cycles after first accept, col_idx 0..15 in order, layer_done high once, the cycle after column 15 handshake, REQ-024 holding for every column.
REQ-030 SHALL hold out_ready = 0 for 4 cycles with in_valid = 1 -> exactly 2 columns accepted then in_ready = 0; out_y*/col_idx stable; after release, columns emerge in order with none lost.
REQ-031 SHALL assert flush together with in_valid = 1 while 2 columns are in flight -> next cycle out_valid = 0, col_idx = 0, that input not accepted, no layer_done.
REQ-032 SHALL pulse rst_n low asynchronously between clock edges at column 7 -> outputs reach reset values immediately; after release, first result carries col_idx = 0.
